// File: rtl/ins_pkg.sv
// Shared constants for the 12-bit instruction frame used by the send and receive blocks.
package ins_pkg;

  localparam int FRAME_W   = 12;
  localparam int INS_W     = 4;
  localparam int BIT_W     = $clog2(FRAME_W);
  localparam int START_BIT = 0;
  localparam int INS_LSB   = 2;
  localparam int INS_MSB   = 5;

  // Bits covered by FIX_MASK must equal FIX_VAL; the instruction field is excluded
  localparam logic [FRAME_W-1:0] FIX_MASK = 12'hFC3;
  localparam logic [FRAME_W-1:0] FIX_VAL  = 12'hC03;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_FMT  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

endpackage

// File: rtl/ins_frame_check.sv
// Combinational frame checker: validates the fixed fields and extracts the instruction.
module ins_frame_check
  import ins_pkg::*;
(
  input  logic [FRAME_W-1:0] frame_i,
  output logic               ok_o,
  output logic [INS_W-1:0]   ins_o
);

  assign ok_o  = ((frame_i & FIX_MASK) == FIX_VAL);
  assign ins_o = frame_i[INS_MSB:INS_LSB];

endmodule

// File: rtl/recv_ins.sv
// Serial instruction-frame receiver: assembles a 12-bit frame LSB first, checks it,
// and reports the instruction or an error with single-cycle pulses.
module recv_ins
  import ins_pkg::*;
#(
  parameter logic [3:0]  MY_ADDR = 4'b0010,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clkins,
  input  logic             rstins,
  input  logic             bittick,
  input  logic             sdains,
  input  logic [3:0]       addins,
  output logic [INS_W-1:0] insout,
  output logic             insvalid,
  output logic             inserr,
  output logic [1:0]       errcode,
  output logic             busy
);

  localparam int GAP_W = $clog2(TIMEOUT);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-2:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0]   gapcnt_q, gapcnt_d;
  logic [INS_W-1:0]   insout_q, insout_d;
  logic               insvalid_q, insvalid_d;
  logic               inserr_q, inserr_d;
  logic [1:0]         errcode_q, errcode_d;

  logic [FRAME_W-1:0] frame_full;
  logic               frame_ok;
  logic [INS_W-1:0]   frame_ins;

  // The last bit is never stored; it is checked straight off the line
  assign frame_full = {sdains, shreg_q};

  ins_frame_check u_check (
    .frame_i (frame_full),
    .ok_o    (frame_ok),
    .ins_o   (frame_ins)
  );

  always_ff @(posedge clkins) begin
    if (rstins) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      gapcnt_q   <= '0;
      insout_q   <= '0;
      insvalid_q <= 1'b0;
      inserr_q   <= 1'b0;
      errcode_q  <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      gapcnt_q   <= gapcnt_d;
      insout_q   <= insout_d;
      insvalid_q <= insvalid_d;
      inserr_q   <= inserr_d;
      errcode_q  <= errcode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    gapcnt_d   = gapcnt_q;
    insout_d   = insout_q;
    insvalid_d = 1'b0;
    inserr_d   = 1'b0;
    errcode_d  = ERR_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (bittick && sdains && (addins == MY_ADDR)) begin
          state_d            = ST_SHIFT;
          shreg_d            = '0;
          shreg_d[START_BIT] = 1'b1;
          bitcnt_d           = BIT_W'(1);
          gapcnt_d           = '0;
        end
      end

      ST_SHIFT: begin
        // A bit strobe always beats the timeout terminal count
        if (bittick) begin
          gapcnt_d = '0;
          if (bitcnt_q == LAST_BIT) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            if (frame_ok) begin
              insout_d   = frame_ins;
              insvalid_d = 1'b1;
            end else begin
              inserr_d  = 1'b1;
              errcode_d = ERR_FMT;
            end
          end else begin
            shreg_d[bitcnt_q] = sdains;
            bitcnt_d          = bitcnt_q + BIT_W'(1);
          end
        end else if (gapcnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          bitcnt_d  = '0;
          gapcnt_d  = '0;
          inserr_d  = 1'b1;
          errcode_d = ERR_TMO;
        end else begin
          gapcnt_d = gapcnt_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign insout   = insout_q;
  assign insvalid = insvalid_q;
  assign inserr   = inserr_q;
  assign errcode  = errcode_q;
  assign busy     = (state_q == ST_SHIFT);

endmodule
